// File: rtl/overlay_gen.sv
// overlay_gen: crosshair flag and hollow-square sprite centred on a once-per-frame smoothed target.
// Latency: 2 cycles from scan position / data_valid_in to crosshair_out, sprite_pixel_out and valid_out.
// Backpressure: none; this is a free-running pixel stream with one pixel accepted every cycle.
//
// Ports:
//   clk_in, rst_in                         pixel clock, async active-high reset
//   hcount_in, vcount_in, data_valid_in    scan position and active-area flag
//   new_frame_in                           start-of-vblank pulse; the display centre updates only here
//   com_x_in, com_y_in, com_valid_in       raw centre-of-mass sample and its strobe
//   crosshair_out, sprite_pixel_out        overlay layers (a sprite value of 0 means transparent)
//   valid_out                              data_valid_in aligned to the overlay outputs
//   tracking_out                           high while a target is being tracked
module overlay_gen #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter int          SPRITE_SIZE  = 64,
  parameter int          BORDER       = 2,
  parameter int          SMOOTH_SHIFT = 2,
  parameter int          STALE_FRAMES = 30,
  parameter logic [23:0] SPRITE_COLOR = 24'hFF00FF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic        new_frame_in,
  input  logic [10:0] com_x_in,
  input  logic [9:0]  com_y_in,
  input  logic        com_valid_in,
  output logic        crosshair_out,
  output logic [23:0] sprite_pixel_out,
  output logic        valid_out,
  output logic        tracking_out
);

  localparam int SW = $clog2(STALE_FRAMES + 1);

  localparam logic [10:0]        X_MAX   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]         Y_MAX   = 10'(V_ACTIVE - 1);
  localparam logic signed [12:0] X_MAX_S = 13'(H_ACTIVE - 1);
  localparam logic signed [12:0] Y_MAX_S = 13'(V_ACTIVE - 1);
  localparam logic [11:0]        HALF    = 12'(SPRITE_SIZE / 2);
  localparam logic [11:0]        INNER   = 12'(SPRITE_SIZE / 2 - BORDER);
  localparam logic [SW-1:0]      STALE_LAST = SW'(STALE_FRAMES - 1);

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_LOST} state_t;

  state_t          r_state;
  logic [10:0]     r_sx, r_pend_x;
  logic [9:0]      r_sy, r_pend_y;
  logic            r_pend;
  logic [SW-1:0]   r_stale;
  logic            r_s1_dv, r_s1_cross, r_s1_spr;

  // Clamp raw samples to the active area before they are stored.
  logic [10:0] w_cap_x;
  logic [9:0]  w_cap_y;
  assign w_cap_x = (com_x_in > X_MAX) ? X_MAX : com_x_in;
  assign w_cap_y = (com_y_in > Y_MAX) ? Y_MAX : com_y_in;

  // IIR step s + ((p - s) >>> shift), in 13-bit signed arithmetic so a
  // target moving left/up rounds toward minus infinity rather than wrapping.
  logic signed [12:0] w_dx_f, w_dy_f, w_fx_sum, w_fy_sum;
  logic [10:0]        w_fx;
  logic [9:0]         w_fy;
  assign w_dx_f   = $signed({2'b00, r_pend_x}) - $signed({2'b00, r_sx});
  assign w_dy_f   = $signed({3'b000, r_pend_y}) - $signed({3'b000, r_sy});
  assign w_fx_sum = $signed({2'b00, r_sx}) + (w_dx_f >>> SMOOTH_SHIFT);
  assign w_fy_sum = $signed({3'b000, r_sy}) + (w_dy_f >>> SMOOTH_SHIFT);
  assign w_fx = w_fx_sum[12] ? 11'd0 : (w_fx_sum > X_MAX_S) ? X_MAX : w_fx_sum[10:0];
  assign w_fy = w_fy_sum[12] ? 10'd0 : (w_fy_sum > Y_MAX_S) ? Y_MAX : w_fy_sum[9:0];

  // Pending sample register. A strobe coinciding with new_frame_in wins, so
  // the frame update consumes the older value while the new one stays pending.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend   <= 1'b0;
      r_pend_x <= '0;
      r_pend_y <= '0;
    end else if (com_valid_in) begin
      r_pend   <= 1'b1;
      r_pend_x <= w_cap_x;
      r_pend_y <= w_cap_y;
    end else if (new_frame_in) begin
      r_pend   <= 1'b0;
    end
  end

  // Target state machine; sx/sy only move on new_frame_in, i.e. in blanking.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= ST_INIT;
      r_sx         <= '0;
      r_sy         <= '0;
      r_stale      <= '0;
      tracking_out <= 1'b0;
    end else if (new_frame_in) begin
      case (r_state)
        ST_TRACK: begin
          if (r_pend) begin
            r_sx    <= w_fx;
            r_sy    <= w_fy;
            r_stale <= '0;
          end else begin
            r_stale <= r_stale + 1'b1;
            if (r_stale == STALE_LAST) begin
              r_state      <= ST_LOST;
              tracking_out <= 1'b0;
            end
          end
        end
        default: begin
          // INIT and LOST both reacquire by loading the sample unfiltered.
          if (r_pend) begin
            r_sx         <= r_pend_x;
            r_sy         <= r_pend_y;
            r_stale      <= '0;
            r_state      <= ST_TRACK;
            tracking_out <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage 1: signed offsets from the centre, magnitudes and region tests.
  logic signed [11:0] w_ox, w_oy;
  logic [11:0]        w_ax, w_ay;
  logic               w_en, w_in_reg, w_on_edge;
  assign w_ox      = $signed({1'b0, hcount_in}) - $signed({1'b0, r_sx});
  assign w_oy      = $signed({2'b00, vcount_in}) - $signed({2'b00, r_sy});
  assign w_ax      = w_ox[11] ? 12'(-w_ox) : 12'(w_ox);
  assign w_ay      = w_oy[11] ? 12'(-w_oy) : 12'(w_oy);
  assign w_in_reg  = (w_ax < HALF) && (w_ay < HALF);
  assign w_on_edge = (w_ax >= INNER) || (w_ay >= INNER);
  assign w_en      = data_valid_in && (r_state == ST_TRACK);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_dv    <= 1'b0;
      r_s1_cross <= 1'b0;
      r_s1_spr   <= 1'b0;
    end else begin
      r_s1_dv    <= data_valid_in;
      r_s1_cross <= w_en && ((hcount_in == r_sx) || (vcount_in == r_sy));
      r_s1_spr   <= w_en && w_in_reg && w_on_edge;
    end
  end

  // Stage 2: colour select and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out        <= 1'b0;
      crosshair_out    <= 1'b0;
      sprite_pixel_out <= '0;
    end else begin
      valid_out        <= r_s1_dv;
      crosshair_out    <= r_s1_cross;
      sprite_pixel_out <= r_s1_spr ? SPRITE_COLOR : 24'h000000;
    end
  end

endmodule
